piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
- Downstream stage for the n-bit universal shift register.
- Captures its parallel word through a valid/ready load handshake and emits it one bit per beat on a serial valid/ready stream.
- Flags the last beat of each frame and allows back-to-back frames with no idle cycle.
- Bridges the parallel shift-register datapath to bit-serial consumers such as line drivers and the verification monitors.

Parameters:
- N, 16: word width in bits; legal values N >= 2.
- MSB_FIRST, 1: 1 sends bit N-1 first; 0 sends bit 0 first.
- CW, $clog2(N+2): width of the beat counter; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous active-low reset; sampled on the clk rising edge.
- par_in  input  N  parallel word, taken from the shift-register data_out.
- load_valid  input  1  par_in holds a word to transmit.
- load_ready  output  1  block accepts par_in this cycle.
- ser_out  output  1  current serial bit.
- ser_valid  output  1  ser_out holds a valid beat.
- ser_ready  input  1  consumer accepts the beat this cycle.
- ser_last  output  1  current beat is the final beat of the frame.
- busy  output  1  frame in progress; equals ser_valid.
- bit_cnt  output  CW  index of the current beat within the frame.

Behaviour:
- State machine: IDLE and SHIFT. Internal registers: shreg[N-1:0] and cnt[CW-1:0].
- Reset (reset==0 at a clk edge):
  - state=IDLE, shreg=0, cnt=0.
  - Outputs: ser_valid=0, busy=0, ser_out=0, ser_last=0, bit_cnt=0.
  - load_ready is forced 0 while reset==0. All inputs are ignored.
- Output decode:
  - ser_valid = (state==SHIFT).
  - ser_out = shreg[N-1] when MSB_FIRST=1, shreg[0] when MSB_FIRST=0. Forced 0 in IDLE.
  - bit_cnt = cnt.
  - ser_last = ser_valid && (cnt==FRAME-1), where FRAME=N (or N+1, see Optional Feature).
- Load handshake: load fires when load_valid && load_ready.
  - load_ready = reset && ((state==IDLE) || (ser_valid && ser_ready && ser_last)).
- IDLE -> SHIFT on load fire: shreg<=par_in, cnt<=0. The first beat is visible the next cycle (latency 1 clk).
- Beat fires when ser_valid && ser_ready.
  - Non-final beat: shreg shifts toward the output end (left if MSB_FIRST, else right), zero-filled; cnt<=cnt+1.
- Final beat (ser_last) with a load firing in the same cycle: reload shreg<=par_in, cnt<=0, stay in SHIFT. No bubble between frames.
- Final beat without a load: go to IDLE, cnt<=0, shreg<=0.
- Backpressure: while ser_valid && !ser_ready, shreg, cnt, ser_out, ser_last and ser_valid hold stable. No beat is dropped or repeated.
- A load_valid arriving in SHIFT before the final beat fires is not accepted (load_ready=0). Upstream must hold par_in until load fires.
- Reset mid-frame aborts the frame:
  - The next cycle shows ser_valid=0.
  - The partial word is discarded and not resumed.
- par_in changes while not loading have no effect.

Optional Feature:
- Macro: PISO_PARITY_EN.
- When defined:
  - FRAME=N+1. One extra beat follows the N data bits, carrying even parity (XOR reduction of the loaded word, captured at load into a parity register).
  - ser_last is asserted on the parity beat only; bit_cnt reaches N.
  - The back-to-back reload occurs on the parity beat.
- When undefined: FRAME=N, no parity register, ser_last on data bit N-1.

Test Plan:
1. Reset: hold reset=0 for 3 cycles with load_valid=1, par_in=16'hFFFF -> ser_valid=0, load_ready=0, ser_out=0, bit_cnt=0. Cycle after reset=1 -> load_ready=1.
2. MSB_FIRST=1, load 16'hA5C3 with ser_ready=1 constant:
   - ser_valid rises 1 cycle after load.
   - Beats are 1010010111000011 over 16 consecutive cycles.
   - ser_last=1 only on the 16th beat; IDLE the next cycle.
3. Backpressure: same word, ser_ready alternating 1,0 -> each bit held while ready=0, bit sequence identical to scenario 2, frame spans 31 cycles, ser_last stable during the stall.
4. Back-to-back: load 16'hFFFF, then hold load_valid=1 with par_in=16'h0001 -> second load fires on the final beat of the first. 32 contiguous valid beats: sixteen 1s, fifteen 0s, then 1. ser_last on beats 16 and 32.
5. Reset mid-frame: assert reset=0 after 5 beats of 16'hA5C3 -> ser_valid=0, bit_cnt=0 the next cycle. A new load of 16'h8000 then sends 1 followed by fifteen 0s.
6. MSB_FIRST=0, load 16'h0001 -> first beat 1, remaining 15 beats 0.
   - With PISO_PARITY_EN, load 16'h0007 -> 16 data beats, then parity beat=1 with ser_last=1 and bit_cnt=16.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage: loads a word over a valid/ready handshake and
// streams it one bit per beat. Define PISO_PARITY_EN to append an even-parity beat.
module piso_serializer #(
  parameter int N         = 16,
  parameter int MSB_FIRST = 1,
  localparam int CW       = $clog2(N + 2)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  par_in,
  input  logic          load_valid,
  output logic          load_ready,
  output logic          ser_out,
  output logic          ser_valid,
  input  logic          ser_ready,
  output logic          ser_last,
  output logic          busy,
  output logic [CW-1:0] bit_cnt
);

`ifdef PISO_PARITY_EN
  localparam int FRAME = N + 1;
`else
  localparam int FRAME = N;
`endif

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    shreg_q, shreg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            data_bit;
  logic            beat_fire;
  logic            load_fire;
`ifdef PISO_PARITY_EN
  logic            par_q, par_d;
`endif

  assign ser_valid = (state_q == SHIFT);
  assign busy      = ser_valid;
  assign bit_cnt   = cnt_q;
  assign ser_last  = ser_valid && (cnt_q == CW'(FRAME - 1));
  assign beat_fire = ser_valid && ser_ready;

  // A new word is taken when idle, or on the final beat so frames run back to back.
  assign load_ready = reset && (!ser_valid || (beat_fire && ser_last));
  assign load_fire  = load_valid && load_ready;

  assign data_bit = (MSB_FIRST != 0) ? shreg_q[N-1] : shreg_q[0];

`ifdef PISO_PARITY_EN
  assign ser_out = ser_valid && ((cnt_q == CW'(N)) ? par_q : data_bit);
`else
  assign ser_out = ser_valid && data_bit;
`endif

  always_comb begin
    // NOTE: every _d gets a hold default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
`ifdef PISO_PARITY_EN
    par_d   = par_q;
`endif
    if (load_fire) begin
      state_d = SHIFT;
      shreg_d = par_in;
      cnt_d   = '0;
`ifdef PISO_PARITY_EN
      par_d   = ^par_in;
`endif
    end else if (beat_fire) begin
      if (ser_last) begin
        state_d = IDLE;
        shreg_d = '0;
        cnt_d   = '0;
      end else begin
        if (MSB_FIRST != 0) shreg_d = {shreg_q[N-2:0], 1'b0};
        else                shreg_d = {1'b0, shreg_q[N-1:1]};
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: an MSB-first and an LSB-first instance,
// expected beats queued at stimulus time and popped by a negedge monitor.
module tb_piso_serializer;

  localparam int N = 16;
`ifdef PISO_PARITY_EN
  localparam int FRAME  = N + 1;
  localparam bit PAR_EN = 1'b1;
`else
  localparam int FRAME  = N;
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct {
    int   sel;
    logic b;
    logic last;
    int   cnt;
  } beat_t;

  beat_t sb_q[$];

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  lv, rdy;
  logic [15:0] par0, par1;
  wire  [1:0]  lr, sv, so, sl, bz;
  wire  [4:0]  bc0, bc1;

  int n_checks = 0;
  int n_fail   = 0;
  int beats    = 0;
  int cyc, c1, c2;

  logic [1:0] held_v = 2'b00;
  logic [6:0] snap [2];

  piso_serializer #(.N(N), .MSB_FIRST(1)) dut_m (
    .clk(clk), .reset(reset), .par_in(par0), .load_valid(lv[0]), .load_ready(lr[0]),
    .ser_out(so[0]), .ser_valid(sv[0]), .ser_ready(rdy[0]), .ser_last(sl[0]),
    .busy(bz[0]), .bit_cnt(bc0)
  );

  piso_serializer #(.N(N), .MSB_FIRST(0)) dut_l (
    .clk(clk), .reset(reset), .par_in(par1), .load_valid(lv[1]), .load_ready(lr[1]),
    .ser_out(so[1]), .ser_valid(sv[1]), .ser_ready(rdy[1]), .ser_last(sl[1]),
    .busy(bz[1]), .bit_cnt(bc1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue the first ndata data beats of word w; the parity beat follows a full frame.
  task automatic push_frame(input int sel, input logic [15:0] w, input bit msb, input int ndata);
    beat_t e;
    for (int k = 0; k < ndata; k++) begin
      e.sel  = sel;
      e.b    = msb ? w[N-1-k] : w[k];
      e.last = (k == FRAME - 1);
      e.cnt  = k;
      sb_q.push_back(e);
    end
    if (PAR_EN && ndata == N) begin
      e.sel  = sel;
      e.b    = ^w;
      e.last = 1'b1;
      e.cnt  = N;
      sb_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [6:0] cur;
      beat_t      e;
      cur = {so[i], sl[i], (i == 0) ? bc0 : bc1};
      if (held_v[i] && sv[i]) check($sformatf("stall_hold%0d", i), {25'b0, cur}, {25'b0, snap[i]});
      held_v[i] = sv[i] && !rdy[i];
      snap[i]   = cur;
      if (sv[i] && rdy[i]) begin
        beats++;
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat dut%0d: got beat %0h expected none at %0t", i, cur, $time);
        end else begin
          e = sb_q.pop_front();
          check($sformatf("beat_dut%0d_idx%0d", i, e.cnt),
                {23'b0, 1'(i), so[i], sl[i], cur[4:0], bz[i]},
                {23'b0, 1'(e.sel), e.b, e.last, e.cnt[4:0], 1'b1});
        end
      end
    end
  end

  task automatic set_par(input int sel, input logic [15:0] w);
    if (sel == 0) par0 = w;
    else          par1 = w;
  endtask

  // Called #1 after a posedge; returns #1 after the posedge where the load fired.
  task automatic do_load(input int sel, input logic [15:0] w);
    int t;
    bit ok;
    t  = 0;
    ok = 1'b0;
    set_par(sel, w);
    lv[sel] = 1'b1;
    while (!ok && t < 50) begin
      @(negedge clk);
      ok = lr[sel];
      t++;
    end
    check($sformatf("load_accept%0d", sel), {31'b0, ok}, 32'd1);
    @(posedge clk);
    #1;
    lv[sel] = 1'b0;
    set_par(sel, 16'hDEAD);
  endtask

  task automatic run_frame(input int sel, input int nb, input bit alt, output int cycles);
    int start;
    start  = beats;
    cycles = 0;
    rdy[sel] = 1'b1;
    while (beats - start < nb && cycles < 400) begin
      @(posedge clk);
      cycles++;
      #1;
      if (alt) rdy[sel] = ~rdy[sel];
    end
    rdy[sel] = 1'b1;
  endtask

  task automatic check_idle(input int sel);
    @(negedge clk);
    check($sformatf("idle_after_frame%0d", sel), {31'b0, sv[sel]}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish by %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    lv    = 2'b01;
    rdy   = 2'b11;
    par0  = 16'hFFFF;
    par1  = 16'h0000;

    // Reset held with a pending load: nothing may be accepted or emitted.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ser_valid", {31'b0, sv[0]}, 32'd0);
    check("rst_load_ready", {31'b0, lr[0]}, 32'd0);
    check("rst_ser_out", {31'b0, so[0]}, 32'd0);
    check("rst_bit_cnt", {27'b0, bc0}, 32'd0);
    check("rst_ser_last", {31'b0, sl[0]}, 32'd0);
    check("rst_busy", {31'b0, bz[0]}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    lv    = 2'b00;
    @(negedge clk);
    check("post_rst_load_ready0", {31'b0, lr[0]}, 32'd1);
    check("post_rst_load_ready1", {31'b0, lr[1]}, 32'd1);
    @(posedge clk);
    #1;

    // Single frame, consumer always ready: FRAME contiguous beats.
    push_frame(0, 16'hA5C3, 1'b1, N);
    do_load(0, 16'hA5C3);
    run_frame(0, FRAME, 1'b0, cyc);
    check("t2_frame_cycles", cyc, FRAME);
    check_idle(0);

    // Alternating backpressure: one stall between every pair of beats.
    @(posedge clk);
    #1;
    push_frame(0, 16'hA5C3, 1'b1, N);
    do_load(0, 16'hA5C3);
    run_frame(0, FRAME, 1'b1, cyc);
    check("t3_frame_cycles", cyc, 2 * FRAME - 1);
    check_idle(0);

    // Back-to-back frames: second load held pending until the final beat.
    @(posedge clk);
    #1;
    push_frame(0, 16'hFFFF, 1'b1, N);
    push_frame(0, 16'h0001, 1'b1, N);
    do_load(0, 16'hFFFF);
    par0  = 16'h0001;
    lv[0] = 1'b1;
    run_frame(0, FRAME, 1'b0, c1);
    lv[0] = 1'b0;
    run_frame(0, FRAME, 1'b0, c2);
    check("t4_first_frame_cycles", c1, FRAME);
    check("t4_second_frame_cycles", c2, FRAME);
    check_idle(0);

    // Reset after 5 beats aborts the frame; the next word starts clean.
    @(posedge clk);
    #1;
    push_frame(0, 16'hA5C3, 1'b1, 5);
    do_load(0, 16'hA5C3);
    run_frame(0, 5, 1'b0, cyc);
    check("t5_partial_cycles", cyc, 5);
    rdy[0] = 1'b0;
    reset  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t5_abort_ser_valid", {31'b0, sv[0]}, 32'd0);
    check("t5_abort_bit_cnt", {27'b0, bc0}, 32'd0);
    check("t5_abort_load_ready", {31'b0, lr[0]}, 32'd0);
    @(posedge clk);
    #1;
    reset  = 1'b1;
    rdy[0] = 1'b1;
    push_frame(0, 16'h8000, 1'b1, N);
    do_load(0, 16'h8000);
    run_frame(0, FRAME, 1'b0, cyc);
    check("t5_new_frame_cycles", cyc, FRAME);
    check_idle(0);

    // LSB-first instance.
    @(posedge clk);
    #1;
    push_frame(1, 16'h0001, 1'b0, N);
    do_load(1, 16'h0001);
    run_frame(1, FRAME, 1'b0, cyc);
    check("t6_lsb_0001_cycles", cyc, FRAME);
    check_idle(1);
    @(posedge clk);
    #1;
    push_frame(1, 16'h0007, 1'b0, N);
    do_load(1, 16'h0007);
    run_frame(1, FRAME, 1'b0, cyc);
    check("t6_lsb_0007_cycles", cyc, FRAME);
    check_idle(1);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
